// File: rtl/bus_read_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// bus_read_scheduler_pkg
// Shared constants and helpers for the bus read scheduler slice.
//   C_LOG_2              : ceiling log2 with a minimum of 1 (tag/counter widths)
//   BUS_FIFO_DEPTH       : default depth of the per-lane fifo_bus_read instances
//   BUS_SCHED_OBUF_DEPTH : entries in the scheduler output buffer
//   obuf_occ_e           : output buffer occupancy encoding
// ---------------------------------------------------------------------------
package bus_read_scheduler_pkg;

    localparam int BUS_FIFO_DEPTH       = 16;
    localparam int BUS_SCHED_OBUF_DEPTH = 2;

    typedef enum logic [1:0] {
        OBUF_EMPTY = 2'd0,
        OBUF_ONE   = 2'd1,
        OBUF_FULL  = 2'd2
    } obuf_occ_e;

    function automatic int C_LOG_2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_read_scheduler_if.sv
// ---------------------------------------------------------------------------
// bus_read_scheduler_if
// Bundles the FIFO-bank side and the consumer side of the read scheduler.
//   fifo_empty   : per-FIFO empty flags (FIFO -> scheduler)
//   fifo_rd_data : per-FIFO read data, FIFO i at [i*DATA_LEN +: DATA_LEN]
//   fifo_rd_en   : one-hot or zero read strobe (scheduler -> FIFO)
//   sched_en     : grant enable
//   out_data/out_id/out_valid : head word of the output buffer
//   out_ready    : consumer accepts head word when out_valid && out_ready
//   busy         : read in flight or output buffer non-empty
// Modports: master = scheduler side, slave = FIFO bank / consumer side.
// ---------------------------------------------------------------------------
interface bus_read_scheduler_if
    import bus_read_scheduler_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int DATA_LEN  = 16,
    parameter int ID_LEN    = C_LOG_2(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0]          fifo_empty;
    logic [NUM_FIFOS*DATA_LEN-1:0] fifo_rd_data;
    logic [NUM_FIFOS-1:0]          fifo_rd_en;
    logic                          sched_en;
    logic [DATA_LEN-1:0]           out_data;
    logic [ID_LEN-1:0]             out_id;
    logic                          out_valid;
    logic                          out_ready;
    logic                          busy;

    modport master (
        input  fifo_empty, fifo_rd_data, sched_en, out_ready,
        output fifo_rd_en, out_data, out_id, out_valid, busy
    );

    modport slave (
        output fifo_empty, fifo_rd_data, sched_en, out_ready,
        input  fifo_rd_en, out_data, out_id, out_valid, busy
    );

endinterface

// File: rtl/bus_read_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first requesting index at or
// after i_ptr, wrapping modulo N. The pointer register lives in the parent.
//   i_req   : request vector
//   i_ptr   : search start index (must be < N)
//   o_grant : one-hot grant, zero when nothing requests
//   o_idx   : index of the granted requester
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Walk ptr, ptr+1, ... with an explicit wrap so N need not be a power of two.
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/bus_read_scheduler.sv
// ---------------------------------------------------------------------------
// bus_read_scheduler
// Round-robin read scheduler for a bank of bus read FIFOs sharing one
// downstream datapath. Each cycle one non-empty FIFO gets a read strobe, its
// word is captured the following cycle into a 2-entry output buffer and is
// presented on a valid/ready port tagged with the source FIFO index.
//
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : bus_read_scheduler_if.master (FIFO bank + consumer handshake)
//
// Parameters: NUM_FIFOS (>=2), DATA_LEN, ID_LEN, BURST_LEN.
//
// Configuration macro BUS_SCHED_BURST_EN: when defined, the scheduler keeps
// granting the same FIFO for up to BURST_LEN consecutive issues before the
// round-robin pointer moves on; when undefined, pure round robin.
// ---------------------------------------------------------------------------
module bus_read_scheduler
    import bus_read_scheduler_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int DATA_LEN  = 16,
    parameter int ID_LEN    = C_LOG_2(NUM_FIFOS),
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    bus_read_scheduler_if.master bus
);

    if (NUM_FIFOS < 2 || BURST_LEN < 1) begin : g_cfg_check
        $error("bus_read_scheduler: NUM_FIFOS must be >= 2 and BURST_LEN >= 1");
    end

    function automatic logic [ID_LEN-1:0] idx_inc(input logic [ID_LEN-1:0] v);
        return (v == ID_LEN'(NUM_FIFOS - 1)) ? '0 : v + 1'b1;
    endfunction

    logic [NUM_FIFOS-1:0] w_req;
    logic [NUM_FIFOS-1:0] w_grant;
    logic [ID_LEN-1:0]    w_gidx;
    logic                 w_any;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [2:0]           w_level;
    logic [DATA_LEN-1:0]  w_cap_data;
    logic [DATA_LEN-1:0]  w_lane [NUM_FIFOS];
    obuf_occ_e            w_occ_nxt;

    logic [ID_LEN-1:0]    r_ptr;
    logic                 r_inflight_p1;
    logic [ID_LEN-1:0]    r_tag_p1;
    obuf_occ_e            r_occ;
    logic [DATA_LEN-1:0]  r_head_data;
    logic [ID_LEN-1:0]    r_head_id;
    logic [DATA_LEN-1:0]  r_tail_data;
    logic [ID_LEN-1:0]    r_tail_id;
    logic                 r_out_valid;
    logic                 r_busy;

    for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_lane
        assign w_lane[gi] = bus.fifo_rd_data[gi*DATA_LEN +: DATA_LEN];
    end

    // ---- Stage p0: arbitration and read strobe -----------------------------
    assign w_req = ~bus.fifo_empty;

    rr_arbiter #(
        .N  (NUM_FIFOS),
        .IW (ID_LEN)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_pop = r_out_valid && bus.out_ready;

    // Words that will occupy the buffer once this cycle's pop retires; a new
    // read is only allowed if its word is guaranteed a slot.
    assign w_level = 3'(r_occ) + {2'b00, r_inflight_p1} - {2'b00, w_pop};

    // rstn gates the strobe so nothing is consumed from a FIFO while in reset.
    assign w_issue = rstn && bus.sched_en && w_any &&
                     (w_level < 3'(BUS_SCHED_OBUF_DEPTH));

    assign bus.fifo_rd_en = w_issue ? w_grant : '0;

`ifdef BUS_SCHED_BURST_EN
    localparam int BCNT_W = C_LOG_2(BURST_LEN + 1);

    logic [BCNT_W-1:0] r_bcnt;
    logic [ID_LEN-1:0] r_last;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic              w_same;

    // The pointer parks on the bursting FIFO so the arbiter re-picks it while
    // it stays eligible; an empty FIFO is skipped naturally by the search.
    assign w_same     = (r_bcnt != '0) && (w_gidx == r_last) &&
                        (r_bcnt < BCNT_W'(BURST_LEN));
    assign w_bcnt_nxt = w_same ? r_bcnt + 1'b1 : BCNT_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr  <= '0;
            r_bcnt <= '0;
            r_last <= '0;
        end else if (w_issue) begin
            r_bcnt <= w_bcnt_nxt;
            r_last <= w_gidx;
            r_ptr  <= (w_bcnt_nxt >= BCNT_W'(BURST_LEN)) ? idx_inc(w_gidx) : w_gidx;
        end else if (r_bcnt != '0) begin
            // A cycle without issue ends the burst.
            r_bcnt <= '0;
            r_ptr  <= idx_inc(r_last);
        end
    end
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= idx_inc(w_gidx);
        end
    end
`endif

    // ---- Stage p1: read in flight, capture returned word -------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight_p1 <= 1'b0;
            r_tag_p1      <= '0;
        end else begin
            r_inflight_p1 <= w_issue;
            if (w_issue) begin
                r_tag_p1 <= w_gidx;
            end
        end
    end

    assign w_push     = r_inflight_p1;
    assign w_cap_data = w_lane[r_tag_p1];

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = (r_occ == OBUF_EMPTY) ? OBUF_ONE : OBUF_FULL;
            2'b01:   w_occ_nxt = (r_occ == OBUF_FULL) ? OBUF_ONE : OBUF_EMPTY;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // ---- Stage p2: output buffer (head entry drives the outputs) -----------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ       <= OBUF_EMPTY;
            r_head_data <= '0;
            r_head_id   <= '0;
            r_tail_data <= '0;
            r_tail_id   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_occ       <= w_occ_nxt;
            r_out_valid <= (w_occ_nxt != OBUF_EMPTY);
            r_busy      <= w_issue || (w_occ_nxt != OBUF_EMPTY);
            if (w_pop && !w_push) begin
                r_head_data <= r_tail_data;
                r_head_id   <= r_tail_id;
            end else if (w_push && !w_pop) begin
                if (r_occ == OBUF_EMPTY) begin
                    r_head_data <= w_cap_data;
                    r_head_id   <= r_tag_p1;
                end else begin
                    r_tail_data <= w_cap_data;
                    r_tail_id   <= r_tag_p1;
                end
            end else if (w_push && w_pop) begin
                // Occupancy is unchanged: the new word lands behind whatever
                // remains after the head leaves.
                if (r_occ == OBUF_ONE) begin
                    r_head_data <= w_cap_data;
                    r_head_id   <= r_tag_p1;
                end else begin
                    r_head_data <= r_tail_data;
                    r_head_id   <= r_tail_id;
                    r_tail_data <= w_cap_data;
                    r_tail_id   <= r_tag_p1;
                end
            end
        end
    end

    assign bus.out_data  = r_head_data;
    assign bus.out_id    = r_head_id;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_bus_read_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bus_read_scheduler
// Directed bench for bus_read_scheduler with a behavioural model of four
// fifo_bus_read instances (registered read data, empty from pointers).
// ---------------------------------------------------------------------------
module tb_bus_read_scheduler;

    localparam int NF = 4;
    localparam int DL = 16;
    localparam int IL = 2;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_read_scheduler_if #(.NUM_FIFOS(NF), .DATA_LEN(DL), .ID_LEN(IL)) bus ();

    bus_read_scheduler #(
        .NUM_FIFOS (NF),
        .DATA_LEN  (DL),
        .ID_LEN    (IL),
        .BURST_LEN (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // FIFO bank model
    logic [DL-1:0] mem [NF][64];
    logic [DL-1:0] r_rdata [NF];
    int            rptr [NF];
    int            wptr [NF];

    initial begin
        for (int i = 0; i < NF; i++) begin
            rptr[i]    = 0;
            wptr[i]    = 0;
            r_rdata[i] = '0;
        end
    end

    assign bus.fifo_empty   = {rptr[3] == wptr[3], rptr[2] == wptr[2],
                               rptr[1] == wptr[1], rptr[0] == wptr[0]};
    assign bus.fifo_rd_data = {r_rdata[3], r_rdata[2], r_rdata[1], r_rdata[0]};

    always @(posedge clk) begin
        for (int i = 0; i < NF; i++) begin
            if (bus.fifo_rd_en[i]) begin
                r_rdata[i] <= mem[i][rptr[i][5:0]];
                rptr[i]    <= rptr[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event logs, sampled on the falling edge
    typedef struct { int cyc; int idx; } gnt_t;
    typedef struct { int cyc; int id; int data; } out_t;
    gnt_t gq[$];
    out_t oq[$];

    always @(negedge clk) begin
        chk("rd_en_to_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);
        chk("rd_en_onehot", 32'($countones(bus.fifo_rd_en) > 1), 32'd0);
        for (int i = 0; i < NF; i++) begin
            if (bus.fifo_rd_en[i]) gq.push_back('{cyc, i});
        end
        if (bus.out_valid && bus.out_ready)
            oq.push_back('{cyc, int'(bus.out_id), int'(bus.out_data)});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int f, input int n, input logic [DL-1:0] base);
        for (int k = 0; k < n; k++) begin
            mem[f][wptr[f][5:0]] = base + DL'(k);
            wptr[f] = wptr[f] + 1;
        end
    endtask

    task automatic clear_logs();
        gq.delete();
        oq.delete();
    endtask

    task automatic rst_pulse();
        bus.sched_en = 1'b0;
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(1);
        clear_logs();
    endtask

    int exp6 [12];
    int cnt6 [NF];

    initial begin
        rstn          = 1'b0;
        bus.sched_en  = 1'b0;
        bus.out_ready = 1'b0;
        step(3);

        // Reset values
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_id", 32'(bus.out_id), 32'd0);

        // Single FIFO: FIFO 2 holds A1..A3; no strobe while reset is held
        load(2, 3, 16'h00A1);
        bus.sched_en = 1'b1;
        #1;
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        step(1);
        clear_logs();
        bus.out_ready = 1'b1;
        rstn = 1'b1;
        step(8);
        chk("t1_ngnt", gq.size(), 3);
        chk("t1_nout", oq.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < gq.size()) begin
                chk("t1_gidx", gq[k].idx, 2);
                chk("t1_gcyc", gq[k].cyc - gq[0].cyc, k);
            end
            if (k < oq.size() && gq.size() > 0) begin
                chk("t1_oid", oq[k].id, 2);
                chk("t1_odata", oq[k].data, 32'h00A1 + k);
                chk("t1_ocyc", oq[k].cyc - gq[0].cyc, k + 2);
            end
        end
        chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);

`ifndef BUS_SCHED_BURST_EN
        // Fairness: four FIFOs with 8 words each
        rst_pulse();
        for (int i = 0; i < NF; i++) load(i, 8, DL'(i << 8));
        bus.out_ready = 1'b1;
        bus.sched_en  = 1'b1;
        step(40);
        chk("t2_ngnt", gq.size(), 32);
        chk("t2_nout", oq.size(), 32);
        for (int k = 0; k < 32; k++) begin
            if (k < gq.size()) begin
                chk("t2_gidx", gq[k].idx, k % 4);
                chk("t2_gcyc", gq[k].cyc - gq[0].cyc, k);
            end
            if (k < oq.size() && gq.size() > 0) begin
                chk("t2_oid", oq[k].id, k % 4);
                chk("t2_odata", oq[k].data, ((k % 4) << 8) + k / 4);
                chk("t2_ocyc", oq[k].cyc - gq[0].cyc, k + 2);
            end
        end

        // Back-pressure: consumer stalled with all FIFOs non-empty
        rst_pulse();
        for (int i = 0; i < NF; i++) load(i, 4, DL'((i << 8) + 16'h10));
        bus.out_ready = 1'b0;
        bus.sched_en  = 1'b1;
        step(8);
        chk("t3_ngnt_stall", gq.size(), 2);
        if (gq.size() >= 2) begin
            chk("t3_g0", gq[0].idx, 0);
            chk("t3_g1", gq[1].idx, 1);
        end
        chk("t3_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_head_data", 32'(bus.out_data), 32'h0010);
        chk("t3_head_id", 32'(bus.out_id), 32'd0);
        chk("t3_busy", 32'(bus.busy), 32'd1);
        chk("t3_nout_stall", oq.size(), 0);
        bus.out_ready = 1'b1;
        step(25);
        chk("t3_ngnt", gq.size(), 16);
        chk("t3_nout", oq.size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k < oq.size()) begin
                chk("t3_oid", oq[k].id, k % 4);
                chk("t3_odata", oq[k].data, ((k % 4) << 8) + 16'h10 + k / 4);
                chk("t3_ocyc", oq[k].cyc - oq[0].cyc, k);
            end
        end
        chk("t3_idle_busy", 32'(bus.busy), 32'd0);
`endif

        // Empty guard: FIFO 0 one word, FIFO 1 three words
        rst_pulse();
        load(0, 1, 16'h0010);
        load(1, 3, 16'h0110);
        bus.out_ready = 1'b1;
        bus.sched_en  = 1'b1;
        step(10);
        chk("t4_ngnt", gq.size(), 4);
        chk("t4_nout", oq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) begin
                chk("t4_gidx", gq[k].idx, (k == 0) ? 0 : 1);
                chk("t4_gcyc", gq[k].cyc - gq[0].cyc, k);
            end
            if (k < oq.size()) begin
                chk("t4_odata", oq[k].data, (k == 0) ? 32'h0010 : 32'h0110 + k - 1);
            end
        end

        // Reset mid-stream with a full output buffer
        rst_pulse();
        load(0, 1, 16'h0010);
        for (int i = 1; i < NF; i++) load(i, 4, DL'((i << 8) + 16'h10));
        bus.out_ready = 1'b0;
        bus.sched_en  = 1'b1;
        step(5);
        chk("t5_pre_ngnt", gq.size(), 2);
        chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_pre_id", 32'(bus.out_id), 32'd0);
        chk("t5_pre_busy", 32'(bus.busy), 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_async_busy", 32'(bus.busy), 32'd0);
        chk("t5_async_data", 32'(bus.out_data), 32'd0);
        chk("t5_async_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        @(posedge clk);
        #1;
        clear_logs();
        bus.out_ready = 1'b1;
        rstn = 1'b1;
        step(20);
        chk("t5_ngnt", gq.size(), 11);
        chk("t5_nout", oq.size(), 11);
        if (gq.size() > 0) chk("t5_first_gidx", gq[0].idx, 1);
        if (oq.size() > 0) begin
            chk("t5_first_oid", oq[0].id, 1);
            chk("t5_first_odata", oq[0].data, 32'h0111);
        end
        chk("t5_idle_busy", 32'(bus.busy), 32'd0);

        // Two FIFOs with 6 words each
`ifdef BUS_SCHED_BURST_EN
        exp6 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
`else
        exp6 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
        rst_pulse();
        load(0, 6, 16'h0020);
        load(1, 6, 16'h0120);
        bus.out_ready = 1'b1;
        bus.sched_en  = 1'b1;
        step(20);
        chk("t6_ngnt", gq.size(), 12);
        chk("t6_nout", oq.size(), 12);
        cnt6[0] = 0;
        cnt6[1] = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < gq.size()) chk("t6_gidx", gq[k].idx, exp6[k]);
            if (k < oq.size()) begin
                chk("t6_oid", oq[k].id, exp6[k]);
                chk("t6_odata", oq[k].data, (exp6[k] << 8) + 16'h20 + cnt6[exp6[k]]);
            end
            cnt6[exp6[k]] = cnt6[exp6[k]] + 1;
        end

        bus.sched_en = 1'b0;
        step(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
